ga_selection: RTL and testbench

Parametrised truncation-selection stage for the genetic route optimiser. It sits between the fitness (distance) evaluation and crossover. It scans a population of `N_POP` individuals one per clock and keeps a sorted on-the-fly buffer of the `N_SEL` best. It then presents them best-first on a flat bus with a one-cycle `done` pulse.

---
 rtl/ga_selection.sv | 163 ++++++++++++++++
 tb/tb_ga_selection.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ga_selection.sv
// ga_selection: truncation-selection stage. Scans N_POP individuals, one per
// clock, into a sorted buffer holding the N_SEL best. The results are then
// presented best-first, with a one-cycle done pulse.
//
// Optional feature macro: GA_SELECTION_MAXIMIZE_EN. When it is defined,
// higher fitness ranks better. By default, lower fitness ranks better.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    launch a run (sampled in IDLE only)
//   pop      N_POP chromosomes, individual i at [i*GENE_W +: GENE_W]
//   fit      N_POP fitness values, individual i at [i*FIT_W +: FIT_W]
//   sel_pop  selected chromosomes, slot 0 (LSBs) is best
//   sel_fit  fitness of each selected slot, same ordering
//   busy     high in CLEAR and SCAN
//   done     one-cycle pulse when sel_pop/sel_fit are valid
module ga_selection #(
    parameter int unsigned N_POP  = 50,
    parameter int unsigned N_SEL  = 10,
    parameter int unsigned GENE_W = 150,
    parameter int unsigned FIT_W  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_POP*GENE_W-1:0] pop,
    input  logic [N_POP*FIT_W-1:0]  fit,
    output logic [N_SEL*GENE_W-1:0] sel_pop,
    output logic [N_SEL*FIT_W-1:0]  sel_fit,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IDX_W = (N_POP > 1) ? $clog2(N_POP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POP - 1);

`ifdef GA_SELECTION_MAXIMIZE_EN
    localparam bit MAXIMIZE = 1'b1;
`else
    localparam bit MAXIMIZE = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_SEL-1:0]   valid_q, valid_d;
    logic [FIT_W-1:0]   slot_fit_q  [N_SEL];
    logic [FIT_W-1:0]   slot_fit_d  [N_SEL];
    logic [GENE_W-1:0]  slot_gene_q [N_SEL];
    logic [GENE_W-1:0]  slot_gene_d [N_SEL];

    logic [GENE_W-1:0]  pop_arr [N_POP];
    logic [FIT_W-1:0]   fit_arr [N_POP];
    logic [GENE_W-1:0]  cand_gene;
    logic [FIT_W-1:0]   cand_fit;
    // keep[j]: slot j is valid and ranks at-or-ahead of the candidate
    logic [N_SEL-1:0]   keep;

    // Unpack the flat input buses.
    for (genvar gi = 0; gi < N_POP; gi++) begin : g_unpack
        assign pop_arr[gi] = pop[gi*GENE_W +: GENE_W];
        assign fit_arr[gi] = fit[gi*FIT_W +: FIT_W];
    end

    // Outputs come straight from the buffer registers.
    for (genvar gs = 0; gs < N_SEL; gs++) begin : g_pack
        assign sel_pop[gs*GENE_W +: GENE_W] = slot_gene_q[gs];
        assign sel_fit[gs*FIT_W +: FIT_W]   = slot_fit_q[gs];
    end

    assign busy = busy_q;
    assign done = done_q;

    // Next-state logic and registered status outputs.
    always_comb begin
        state_d = state_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: state_d = S_SCAN;
            S_SCAN:  if (idx_q == LAST_IDX) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_CLEAR) || (state_d == S_SCAN);
        done_d = (state_d == S_DONE);
    end

    // Sorted insert. The valid slots always form a sorted prefix, so the
    // keep mask is a prefix too, and its first zero is the insert point.
    always_comb begin
        cand_gene = pop_arr[idx_q];
        cand_fit  = fit_arr[idx_q];
        for (int j = 0; j < N_SEL; j++) begin
            keep[j] = valid_q[j] && (MAXIMIZE ? (slot_fit_q[j] >= cand_fit)
                                              : (slot_fit_q[j] <= cand_fit));
        end

        idx_d       = idx_q;
        valid_d     = valid_q;
        slot_fit_d  = slot_fit_q;
        slot_gene_d = slot_gene_q;

        if (state_q == S_CLEAR) begin
            valid_d = '0;
            idx_d   = '0;
        end else if (state_q == S_SCAN) begin
            if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
            if (!keep[0]) begin
                slot_fit_d[0]  = cand_fit;
                slot_gene_d[0] = cand_gene;
                valid_d[0]     = 1'b1;
            end
            for (int j = 1; j < N_SEL; j++) begin
                if (!keep[j]) begin
                    if (keep[j-1]) begin
                        slot_fit_d[j]  = cand_fit;
                        slot_gene_d[j] = cand_gene;
                        valid_d[j]     = 1'b1;
                    end else begin
                        slot_fit_d[j]  = slot_fit_q[j-1];
                        slot_gene_d[j] = slot_gene_q[j-1];
                        valid_d[j]     = valid_q[j-1];
                    end
                end
            end
        end
    end

    // State and buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            valid_q <= '0;
            for (int j = 0; j < N_SEL; j++) begin
                slot_fit_q[j]  <= '0;
                slot_gene_q[j] <= '0;
            end
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            slot_fit_q  <= slot_fit_d;
            slot_gene_q <= slot_gene_d;
        end
    end

endmodule

// File: tb/tb_ga_selection.sv
// tb_ga_selection: randomized plus directed checks of ga_selection against a
// behavioural best-N reference model.
module tb_ga_selection;

    localparam int unsigned N_POP  = 8;
    localparam int unsigned N_SEL  = 3;
    localparam int unsigned GENE_W = 8;
    localparam int unsigned FIT_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [N_POP*GENE_W-1:0] pop;
    logic [N_POP*FIT_W-1:0]  fit;
    logic [N_SEL*GENE_W-1:0] sel_pop;
    logic [N_SEL*FIT_W-1:0]  sel_fit;
    logic                    busy;
    logic                    done;

    int n_tests = 0;
    int n_fail  = 0;

    ga_selection #(
        .N_POP (N_POP),
        .N_SEL (N_SEL),
        .GENE_W(GENE_W),
        .FIT_W (FIT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pop    (pop),
        .fit    (fit),
        .sel_pop(sel_pop),
        .sel_fit(sel_fit),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit better(input int a, input int b);
`ifdef GA_SELECTION_MAXIMIZE_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    // Reference: repeatedly pick the best unused individual. Scanning in
    // ascending index order with a strict compare keeps ties stable.
    task automatic model(input int f[N_POP], output int sel[N_SEL]);
        bit used[N_POP];
        for (int i = 0; i < N_POP; i++) used[i] = 1'b0;
        for (int s = 0; s < N_SEL; s++) begin
            int best = -1;
            for (int i = 0; i < N_POP; i++)
                if (!used[i] && (best < 0 || better(f[i], f[best]))) best = i;
            used[best] = 1'b1;
            sel[s] = best;
        end
    endtask

    task automatic run(input string tag, input int f[N_POP], input int g[N_POP],
                       input bit extra_start);
        int sel[N_SEL];
        int done_at  = 0;
        int busy_cnt = 0;
        model(f, sel);
        for (int i = 0; i < N_POP; i++) begin
            pop[i*GENE_W +: GENE_W] = GENE_W'(g[i]);
            fit[i*FIT_W +: FIT_W]   = FIT_W'(f[i]);
        end
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= int'(N_POP) + 6; n++) begin
            @(negedge clk);
            start = (extra_start && (n == 4 || n == 5));
            if (busy) busy_cnt++;
            if (done) begin
                done_at = n;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, done_at, N_POP + 2);
        check({tag, "_busy_cycles"}, busy_cnt, N_POP + 1);
        if (done_at != 0) begin
            for (int s = 0; s < N_SEL; s++) begin
                check($sformatf("%s_fit%0d", tag, s),
                      32'(sel_fit[s*FIT_W +: FIT_W]), f[sel[s]]);
                check($sformatf("%s_pop%0d", tag, s),
                      32'(sel_pop[s*GENE_W +: GENE_W]), g[sel[s]]);
            end
        end
        @(negedge clk);
        check({tag, "_done_pulse_width"}, 32'(done), 0);
        check({tag, "_held_fit0"}, 32'(sel_fit[FIT_W-1:0]), f[sel[0]]);
    endtask

    int genes[N_POP];
    int rgenes[N_POP];
    int fv[N_POP];
    int done_seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pop   = '0;
        fit   = '0;
        for (int i = 0; i < N_POP; i++) genes[i] = 'h10 + i;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sel_fit", 32'(sel_fit), 0);
        check("reset_sel_pop", 32'(sel_pop), 0);

        // Directed vectors from the test plan.
        fv = '{9, 3, 7, 1, 5, 8, 2, 6};
        run("mixed", fv, genes, 1'b0);
        fv = '{4, 4, 4, 4, 4, 4, 4, 4};
        run("ties", fv, genes, 1'b0);
        fv = '{15, 15, 15, 15, 15, 15, 15, 15};
        run("all_ones", fv, genes, 1'b0);
        fv = '{8, 7, 6, 5, 4, 3, 2, 1};
        run("descending", fv, genes, 1'b0);
        fv = '{1, 2, 3, 4, 5, 6, 7, 8};
        run("ascending", fv, genes, 1'b0);

        // Reset four cycles into SCAN aborts the run and zeroes the outputs.
        fv = '{9, 3, 7, 1, 5, 8, 2, 6};
        for (int i = 0; i < N_POP; i++) fit[i*FIT_W +: FIT_W] = FIT_W'(fv[i]);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_sel_fit", 32'(sel_fit), 0);
        check("abort_sel_pop", 32'(sel_pop), 0);
        done_seen = 0;
        for (int n = 0; n < 12; n++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("abort_no_done", done_seen, 0);

        // Reset and start in the same cycle: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", 32'(busy), 0);
        @(negedge clk);
        check("rst_start_idle", 32'(busy), 0);

        // Restart after the abort; a start pulse during SCAN must be ignored.
        run("restart_extra_start", fv, genes, 1'b1);

        // Randomized populations with random genes; small fitness range forces ties.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N_POP; i++) begin
                fv[i]     = (t < 6) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
                rgenes[i] = int'($urandom_range(0, 255));
            end
            run($sformatf("rand%0d", t), fv, rgenes, t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
